// File: rtl/apb_subsystem_bridge_if.sv
// AHB-Lite slave side and APB master side of the subsystem bridge, bundled as one port group.
// The slave modport is the bridge's view. The master modport is the surrounding bus fabric.
interface apb_subsystem_bridge_if #(
   parameter int ADDRWIDTH = 16
);
   logic                 HSEL;
   logic [ADDRWIDTH-1:0] HADDR;
   logic [1:0]           HTRANS;
   logic                 HWRITE;
   logic [31:0]          HWDATA;
   logic                 HREADY;
   logic                 HREADYOUT;
   logic [31:0]          HRDATA;
   logic                 HRESP;

   logic                 PSEL0;
   logic                 PSEL1;
   logic                 PSEL2;
   logic                 PSEL3;
   logic                 PSEL4;
   logic                 PSEL5;
   logic                 PENABLE;
   logic [ADDRWIDTH-1:0] PADDR;
   logic                 PWRITE;
   logic [31:0]          PWDATA;
   logic                 PREADY;
   logic [31:0]          PRDATA;
   logic                 PSLVERR;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
      output HREADYOUT, HRDATA, HRESP,
      output PSEL0, PSEL1, PSEL2, PSEL3, PSEL4, PSEL5, PENABLE, PADDR, PWRITE, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA, HRESP,
      input  PSEL0, PSEL1, PSEL2, PSEL3, PSEL4, PSEL5, PENABLE, PADDR, PWRITE, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_subsystem_bridge.sv
// AHB-Lite to APB bridge: single transfers become two-phase APB accesses to one of six slots.
// Unmapped slots get a two-cycle AHB ERROR response without touching the APB bus.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no transfer in progress, ready to accept
// S_SETUP  | APB setup phase, PSEL high, PENABLE low
// S_ACCESS | APB access phase, waiting for PREADY
// S_DONE   | OKAY completion cycle, may accept the next transfer
// S_ERR1   | first ERROR cycle (HREADYOUT low)
// S_ERR2   | second ERROR cycle (HREADYOUT high), may accept
module apb_subsystem_bridge #(
   parameter int ADDRWIDTH = 16
) (
   input  logic                   i_hclk,
   input  logic                   i_hreset,
   apb_subsystem_bridge_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDRWIDTH-1:0] r_paddr;
   logic                 r_pwrite;
   logic [3:0]           r_slot;
   logic [31:0]          r_pwdata;
   logic [31:0]          r_hrdata;

   logic [3:0]           w_slot_in;
   logic                 w_can_accept;
   logic                 w_accept;
   logic                 w_mapped;
   logic                 w_apb_active;
   logic                 w_unused_ok;

   assign w_slot_in    = bus.HADDR[ADDRWIDTH-1 -: 4];
   assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
   assign w_accept     = w_can_accept && bus.HSEL && bus.HTRANS[1] && bus.HREADY;
   assign w_mapped     = (w_slot_in < 4'd6);
   assign w_unused_ok  = &{1'b0, bus.HADDR[1:0], bus.HTRANS[0]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR2: begin
            if (w_accept) begin
               w_state_nxt = w_mapped ? S_SETUP : S_ERR1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SETUP:  w_state_nxt = S_ACCESS;
         S_ACCESS: begin
            if (bus.PREADY) begin
               w_state_nxt = bus.PSLVERR ? S_ERR1 : S_DONE;
            end
         end
         S_ERR1:   w_state_nxt = S_ERR2;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         r_state  <= S_IDLE;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_slot   <= 4'd0;
         r_pwdata <= 32'd0;
         r_hrdata <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_paddr  <= {bus.HADDR[ADDRWIDTH-1:2], 2'b00};
            r_pwrite <= bus.HWRITE;
            r_slot   <= w_slot_in;
         end
         // AHB write data is valid in the data phase, which coincides with SETUP
         if (r_state == S_SETUP) begin
            r_pwdata <= bus.HWDATA;
         end
         if ((r_state == S_ACCESS) && bus.PREADY && !bus.PSLVERR && !r_pwrite) begin
            r_hrdata <= bus.PRDATA;
         end
      end
   end

   // r_slot is always mapped whenever SETUP/ACCESS is reachable, so the decode stays one-hot
   assign w_apb_active  = (r_state == S_SETUP) || (r_state == S_ACCESS);
   assign bus.PSEL0     = w_apb_active && (r_slot == 4'd0);
   assign bus.PSEL1     = w_apb_active && (r_slot == 4'd1);
   assign bus.PSEL2     = w_apb_active && (r_slot == 4'd2);
   assign bus.PSEL3     = w_apb_active && (r_slot == 4'd3);
   assign bus.PSEL4     = w_apb_active && (r_slot == 4'd4);
   assign bus.PSEL5     = w_apb_active && (r_slot == 4'd5);
   assign bus.PENABLE   = (r_state == S_ACCESS);
   assign bus.PADDR     = r_paddr;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PWDATA    = (r_state == S_SETUP) ? bus.HWDATA : r_pwdata;

   assign bus.HREADYOUT = !(w_apb_active || (r_state == S_ERR1));
   assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
   assign bus.HRDATA    = r_hrdata;

endmodule

// File: tb/tb_apb_subsystem_bridge.sv
// Cycle-by-cycle vector bench for apb_subsystem_bridge: each table row is one HCLK cycle of
// inputs plus the outputs expected during that cycle; reset and wait-state cases are hand-written.
module tb_apb_subsystem_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_subsystem_bridge_if #(.ADDRWIDTH(16)) bus ();
   apb_subsystem_bridge #(.ADDRWIDTH(16)) dut (.i_hclk(clk), .i_hreset(rst), .bus(bus));

   typedef struct packed {
      logic        hsel;
      logic [1:0]  htrans;
      logic        hready;
      logic        hwrite;
      logic [15:0] haddr;
      logic [31:0] hwdata;
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } in_t;

   typedef struct {
      string       name;
      in_t         inp;
      logic [89:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic in_t mk_in(logic hsel, logic [1:0] htrans, logic hready, logic hwrite,
                                 logic [15:0] haddr, logic [31:0] hwdata, logic pready,
                                 logic [31:0] prdata, logic pslverr);
      in_t i;
      i = '{hsel, htrans, hready, hwrite, haddr, hwdata, pready, prdata, pslverr};
      return i;
   endfunction

   function automatic in_t nop();
      return mk_in(1'b0, 2'b00, 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, 32'h0, 1'b0);
   endfunction

   // {hreadyout, hresp, psel[5:0], penable, paddr, pwrite, pwdata, hrdata}
   function automatic logic [89:0] ex(logic hrdy, logic hresp, logic [5:0] psel, logic pen,
                                      logic [15:0] paddr, logic pwrite, logic [31:0] pwdata,
                                      logic [31:0] hrdata);
      return {hrdy, hresp, psel, pen, paddr, pwrite, pwdata, hrdata};
   endfunction

   function automatic void add(string nm, in_t i, logic [89:0] e);
      vec_t v;
      v.name = nm;
      v.inp  = i;
      v.exp  = e;
      vecs.push_back(v);
   endfunction

   task automatic drive(in_t i);
      bus.HSEL    = i.hsel;
      bus.HTRANS  = i.htrans;
      bus.HREADY  = i.hready;
      bus.HWRITE  = i.hwrite;
      bus.HADDR   = i.haddr;
      bus.HWDATA  = i.hwdata;
      bus.PREADY  = i.pready;
      bus.PRDATA  = i.prdata;
      bus.PSLVERR = i.pslverr;
   endtask

   task automatic check(string nm, logic [89:0] e);
      logic [89:0] a;
      logic [5:0]  ps;
      ps = {bus.PSEL5, bus.PSEL4, bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
      a  = {bus.HREADYOUT, bus.HRESP, ps, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.HRDATA};
      n_vec++;
      if (a !== e || $countones(ps) > 1) begin
         n_err++;
         $display("FAIL %s: got hrdy=%b hresp=%b psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h hrdata=%h | want hrdy=%b hresp=%b psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h hrdata=%h",
                  nm, a[89], a[88], a[87:82], a[81], a[80:65], a[64], a[63:32], a[31:0],
                  e[89], e[88], e[87:82], e[81], e[80:65], e[64], e[63:32], e[31:0]);
      end
   endtask

   initial begin
      int cyc;
      int nacc;
      bit done;

      // write 0x2004, zero-wait
      add("wr_addr",   mk_in(1, 2'b10, 1, 1, 16'h2004, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h0000, 0, 32'h0, 32'h0));
      add("wr_setup",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'hA5A5_0001, 1, 32'h0, 0),  ex(0, 0, 6'b000100, 0, 16'h2004, 1, 32'hA5A5_0001, 32'h0));
      add("wr_access", mk_in(0, 2'b00, 1, 0, 16'h0, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 0), ex(0, 0, 6'b000100, 1, 16'h2004, 1, 32'hA5A5_0001, 32'h0));
      add("wr_done",   nop(),                                                    ex(1, 0, 6'b000000, 0, 16'h2004, 1, 32'hA5A5_0001, 32'h0));
      add("wr_idle",   mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 1, 32'hDEAD_BEEF, 0),  ex(1, 0, 6'b000000, 0, 16'h2004, 1, 32'hA5A5_0001, 32'h0));
      // read 0x5010 with three wait states
      add("rd_addr",   mk_in(1, 2'b10, 1, 0, 16'h5010, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h2004, 1, 32'hA5A5_0001, 32'h0));
      add("rd_setup",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0BAD_0000, 0, 32'hFFFF_FFFF, 0), ex(0, 0, 6'b100000, 0, 16'h5010, 0, 32'h0BAD_0000, 32'h0));
      add("rd_wait1",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 0, 32'hFFFF_FFFF, 0),  ex(0, 0, 6'b100000, 1, 16'h5010, 0, 32'h0BAD_0000, 32'h0));
      add("rd_wait2",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 0, 32'hFFFF_FFFF, 0),  ex(0, 0, 6'b100000, 1, 16'h5010, 0, 32'h0BAD_0000, 32'h0));
      add("rd_wait3",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 0, 32'hFFFF_FFFF, 0),  ex(0, 0, 6'b100000, 1, 16'h5010, 0, 32'h0BAD_0000, 32'h0));
      add("rd_ready",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 1, 32'h1234_5678, 0),  ex(0, 0, 6'b100000, 1, 16'h5010, 0, 32'h0BAD_0000, 32'h0));
      add("rd_done",   nop(),                                                    ex(1, 0, 6'b000000, 0, 16'h5010, 0, 32'h0BAD_0000, 32'h1234_5678));
      // read 0x1003 (SEQ) ending in a slave error
      add("se_addr",   mk_in(1, 2'b11, 1, 0, 16'h1003, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h5010, 0, 32'h0BAD_0000, 32'h1234_5678));
      add("se_setup",  nop(),                                                    ex(0, 0, 6'b000010, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("se_access", mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 1, 32'hAAAA_5555, 1),  ex(0, 0, 6'b000010, 1, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("se_err1",   nop(),                                                    ex(0, 1, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("se_err2",   nop(),                                                    ex(1, 1, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("se_idle",   nop(),                                                    ex(1, 0, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      // qualifiers that must block acceptance, then unmapped 0x9000
      add("no_hready", mk_in(1, 2'b10, 0, 1, 16'h9000, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("no_busy",   mk_in(1, 2'b01, 1, 1, 16'h9000, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("no_hsel",   mk_in(0, 2'b10, 1, 1, 16'h9000, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("um_addr",   mk_in(1, 2'b10, 1, 1, 16'h9000, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h1000, 0, 32'h0, 32'h1234_5678));
      add("um_err1",   nop(),                                                    ex(0, 1, 6'b000000, 0, 16'h9000, 1, 32'h0, 32'h1234_5678));
      add("um_err2",   mk_in(1, 2'b10, 1, 1, 16'h0000, 32'h0, 1, 32'h0, 0),       ex(1, 1, 6'b000000, 0, 16'h9000, 1, 32'h0, 32'h1234_5678));
      // write 0x0000 accepted in ERR2, then 0x3000 accepted in DONE
      add("b2b_setup0",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h1111_0000, 1, 32'h0, 0), ex(0, 0, 6'b000001, 0, 16'h0000, 1, 32'h1111_0000, 32'h1234_5678));
      add("b2b_access0", nop(),                                                  ex(0, 0, 6'b000001, 1, 16'h0000, 1, 32'h1111_0000, 32'h1234_5678));
      add("b2b_done0",   mk_in(1, 2'b10, 1, 1, 16'h3000, 32'h0, 1, 32'h0, 0),     ex(1, 0, 6'b000000, 0, 16'h0000, 1, 32'h1111_0000, 32'h1234_5678));
      add("b2b_setup3",  mk_in(0, 2'b00, 1, 0, 16'h0, 32'h3333_0000, 1, 32'h0, 0), ex(0, 0, 6'b001000, 0, 16'h3000, 1, 32'h3333_0000, 32'h1234_5678));
      add("b2b_access3", nop(),                                                  ex(0, 0, 6'b001000, 1, 16'h3000, 1, 32'h3333_0000, 32'h1234_5678));
      add("b2b_done3",   nop(),                                                  ex(1, 0, 6'b000000, 0, 16'h3000, 1, 32'h3333_0000, 32'h1234_5678));
      // slot 6 is the first unmapped slot
      add("s6_addr",   mk_in(1, 2'b10, 1, 0, 16'h6FFC, 32'h0, 1, 32'h0, 0),       ex(1, 0, 6'b000000, 0, 16'h3000, 1, 32'h3333_0000, 32'h1234_5678));
      add("s6_err1",   nop(),                                                    ex(0, 1, 6'b000000, 0, 16'h6FFC, 0, 32'h3333_0000, 32'h1234_5678));
      add("s6_err2",   nop(),                                                    ex(1, 1, 6'b000000, 0, 16'h6FFC, 0, 32'h3333_0000, 32'h1234_5678));
      add("s6_idle",   nop(),                                                    ex(1, 0, 6'b000000, 0, 16'h6FFC, 0, 32'h3333_0000, 32'h1234_5678));

      drive(nop());
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_state", ex(1, 0, 6'b000000, 0, 16'h0, 0, 32'h0, 32'h0));

      for (int k = 0; k < vecs.size(); k++) begin
         @(posedge clk);
         #1 drive(vecs[k].inp);
         @(negedge clk);
         check(vecs[k].name, vecs[k].exp);
      end

      // reset held for three cycles while a read to slot 4 sits in ACCESS
      @(posedge clk);
      #1 drive(mk_in(1, 2'b10, 1, 0, 16'h4000, 32'h0, 0, 32'h0, 0));
      @(posedge clk);
      #1 drive(mk_in(0, 2'b00, 1, 0, 16'h0, 32'h0, 0, 32'h0, 0));
      @(negedge clk);
      check("rst_setup", ex(0, 0, 6'b010000, 0, 16'h4000, 0, 32'h0, 32'h1234_5678));
      @(negedge clk);
      check("rst_access", ex(0, 0, 6'b010000, 1, 16'h4000, 0, 32'h0, 32'h1234_5678));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_access_hold", ex(0, 0, 6'b010000, 1, 16'h4000, 0, 32'h0, 32'h1234_5678));
      @(negedge clk);
      check("rst_during", ex(1, 0, 6'b000000, 0, 16'h0, 0, 32'h0, 32'h0));
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.PREADY = 1'b1;
      @(negedge clk);
      check("rst_after", ex(1, 0, 6'b000000, 0, 16'h0, 0, 32'h0, 32'h0));

      // read slot 0 with four wait states; completion expected exactly 7 cycles after acceptance
      @(posedge clk);
      #1 drive(mk_in(1, 2'b10, 1, 0, 16'h0008, 32'h0, 0, 32'hCAFE_F00D, 0));
      cyc  = 0;
      nacc = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
         bus.HSEL   = 1'b0;
         bus.HTRANS = 2'b00;
         bus.PREADY = bus.PENABLE && (nacc >= 4);
         if (bus.PENABLE) nacc++;
         @(negedge clk);
         if (bus.HREADYOUT) done = 1'b1;
      end
      n_vec++;
      if (!done || cyc != 7) begin
         n_err++;
         $display("FAIL wait_latency: got done=%0d after %0d cycles, want done=1 after 7 cycles", done, cyc);
      end
      check("wait_done", ex(1, 0, 6'b000000, 0, 16'h0008, 0, 32'h0, 32'hCAFE_F00D));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
